ntt8_butterfly_pipe: RTL and testbench
======================================

Name: ntt8_butterfly_pipe

Overview:
- 8-point radix-2 decimation-in-time NTT butterfly network over Z/mod.
- Takes a bit-reversed-order input vector, caller-supplied twiddles and modulus; produces a natural-order transform.
- Three pipelined butterfly stages, one per log2(8) level; accepts one vector per clock.
- Sits between a bit-reversal/load unit and downstream NTT consumers.

Parameters:
- DATA_W, 8, width of every coefficient, twiddle and modulus.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- valid_in  input  1  input vector present this cycle.
- data_in  input  8 x DATA_W  coefficients, bit-reversed order (index i holds x[bitrev3(i)]).
- omegas  input  4 x DATA_W  twiddles; omegas[k] = w^k, k=0..3.
- mod  input  DATA_W  modulus q, 2 <= q < 2^DATA_W.
- valid_out  output  1  data_out holds a result.
- data_out  output  8 x DATA_W  transform, natural order.

Behaviour:
- One clock. Reset is asynchronous and active-low.
- rst_n low: all pipeline registers clear immediately. valid_out=0 and data_out all 0 until new data flows through.
- Latency: exactly 3 cycles. A vector sampled with valid_in=1 at edge n appears at edge n+3.
- Throughput: 1 vector per cycle. No backpressure and no stall.
- valid_in=0 cycles propagate as bubbles (valid_out=0).
- data_out holds its last value while valid_out=0. It is not cleared.
- mod and omegas are sampled with each vector and carried down the pipeline. Changing them every cycle therefore affects only the vector sampled in the same cycle.
- Butterfly(a, b, w) produces:
  - t = (w*b) mod q, using a 2*DATA_W-bit product.
  - a' = a+t, minus q if a+t >= q (DATA_W+1-bit sum).
  - b' = a-t if a >= t, else a+q-t.
- Stage 1 (span 1): pairs (0,1),(2,3),(4,5),(6,7), all with omegas[0].
- Stage 2 (span 2): pairs (0,2),(4,6) use omegas[0]; pairs (1,3),(5,7) use omegas[2].
- Stage 3 (span 4): pairs (k,k+4) use omegas[k], k=0..3.
- In each pair (i,j), the lower index receives a' and the higher index receives b'.
- Each stage's outputs are registered. Stage 3's register drives data_out.
- Range requirement: all data_in and omegas values must be < q. Every internal and output value is then < q.
- Out-of-range inputs give unspecified values but must not produce X.
- The block does not check that omegas form a valid root of unity; it computes the network with whatever twiddles are supplied.
- Reset asserted mid-stream discards all in-flight vectors. The first vector after release returns 3 cycles after its own valid_in.

Test Plan:
- Reset: hold rst_n=0 with random inputs and valid_in=1 -> valid_out=0, data_out all 0. Release, then drive valid_in=0 -> outputs stay 0.
- Reference vector: q=29, omegas={1,16,24,7}, data_in={0,4,2,6,1,5,3,7}, valid_in one cycle -> 3 cycles later valid_out=1 for one cycle, data_out={28,11,16,11,25,21,5,28}.
- Impulse: q=29, omegas={1,16,24,7}, data_in[4]=1, all others 0 -> data_out={1,16,24,7,28,13,5,22}.
- Streaming: the two vectors above on consecutive cycles, then a zero vector -> results on three consecutive cycles with valid_out high throughout, in order. Zero vector -> all 0.
- Wrap/boundary: q=29, all data_in=28, omegas={1,28,28,28} -> no value >= 29, no X. Compare against a software model of the same network.
- Reset mid-flight: launch 2 vectors, pulse rst_n low asynchronously between clock edges -> outputs clear at once. No stale valid_out after release. A new vector returns correctly after 3 cycles.

Source files
------------

// File: rtl/ntt8_butterfly_pipe.sv
// rtl/ntt8_butterfly_pipe.sv - 8-point radix-2 DIT NTT butterfly network, input register plus three registered stages
module ntt8_butterfly_pipe #(
    parameter int DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid_in,
    input  logic [7:0][DATA_W-1:0] data_in,
    input  logic [3:0][DATA_W-1:0] omegas,
    input  logic [DATA_W-1:0]      mod,
    output logic                   valid_out,
    output logic [7:0][DATA_W-1:0] data_out
);

    typedef logic [DATA_W-1:0] word_t;
    typedef word_t [7:0]       vec_t;
    typedef word_t [3:0]       om_t;

    // Returns {a', b'}; q == 0 is guarded so illegal moduli still give known values.
    function automatic logic [2*DATA_W-1:0] butterfly(word_t a, word_t b, word_t w, word_t q);
        logic [2*DATA_W-1:0] prod;
        logic [DATA_W:0]     sum;
        word_t               t;
        word_t               hi;
        word_t               lo;
        prod = {{DATA_W{1'b0}}, w} * {{DATA_W{1'b0}}, b};
        t    = (q == '0) ? '0 : word_t'(prod % {{DATA_W{1'b0}}, q});
        sum  = {1'b0, a} + {1'b0, t};
        hi   = (sum >= {1'b0, q}) ? word_t'(sum - {1'b0, q}) : sum[DATA_W-1:0];
        lo   = (a >= t) ? word_t'(a - t) : word_t'({1'b0, a} + {1'b0, q} - {1'b0, t});
        return {hi, lo};
    endfunction

    logic  in_v, s1_v, s2_v, s3_v;
    vec_t  in_d, s1_d, s2_d, s3_d;
    om_t   in_om, s1_om, s2_om;
    word_t in_q, s1_q, s2_q;
    vec_t  n1_d, n2_d, n3_d;

    always_comb begin
        n1_d = in_d;
        for (int p = 0; p < 4; p++) begin
            {n1_d[2*p], n1_d[2*p+1]} = butterfly(in_d[2*p], in_d[2*p+1], in_om[0], in_q);
        end
    end

    always_comb begin
        n2_d = s1_d;
        for (int g = 0; g < 2; g++) begin
            for (int m = 0; m < 2; m++) begin
                {n2_d[4*g+m], n2_d[4*g+m+2]} =
                    butterfly(s1_d[4*g+m], s1_d[4*g+m+2], s1_om[2*m], s1_q);
            end
        end
    end

    always_comb begin
        n3_d = s2_d;
        for (int k = 0; k < 4; k++) begin
            {n3_d[k], n3_d[k+4]} = butterfly(s2_d[k], s2_d[k+4], s2_om[k], s2_q);
        end
    end

    // Data, twiddles and modulus only load behind a valid, so bubbles leave outputs holding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_v  <= 1'b0;
            s1_v  <= 1'b0;
            s2_v  <= 1'b0;
            s3_v  <= 1'b0;
            in_d  <= '0;
            s1_d  <= '0;
            s2_d  <= '0;
            s3_d  <= '0;
            in_om <= '0;
            s1_om <= '0;
            s2_om <= '0;
            in_q  <= '0;
            s1_q  <= '0;
            s2_q  <= '0;
        end else begin
            in_v <= valid_in;
            s1_v <= in_v;
            s2_v <= s1_v;
            s3_v <= s2_v;
            if (valid_in) begin
                in_d  <= data_in;
                in_om <= omegas;
                in_q  <= mod;
            end
            if (in_v) begin
                s1_d  <= n1_d;
                s1_om <= in_om;
                s1_q  <= in_q;
            end
            if (s1_v) begin
                s2_d  <= n2_d;
                s2_om <= s1_om;
                s2_q  <= s1_q;
            end
            if (s2_v) begin
                s3_d <= n3_d;
            end
        end
    end

    assign valid_out = s3_v;
    assign data_out  = s3_d;

endmodule

// File: tb/tb_ntt8_butterfly_pipe.sv
// tb/tb_ntt8_butterfly_pipe.sv - self-checking bench for ntt8_butterfly_pipe against an even/odd NTT model
module tb_ntt8_butterfly_pipe;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            valid_in;
    logic [7:0][7:0] data_in;
    logic [3:0][7:0] omegas;
    logic [7:0]      mod;
    logic            valid_out;
    logic [7:0][7:0] data_out;

    ntt8_butterfly_pipe #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .omegas    (omegas),
        .mod       (mod),
        .valid_out (valid_out),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            v;
        logic [63:0]     d;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] last_d;
    int          tests;
    int          fails;

    int ref_in[8]  = '{0, 4, 2, 6, 1, 5, 3, 7};
    int ref_out[8] = '{28, 11, 16, 11, 25, 21, 5, 28};
    int imp_out[8] = '{1, 16, 24, 7, 28, 13, 5, 22};
    int std_om[4]  = '{1, 16, 24, 7};

    function automatic int md(int v, int q);
        return ((v % q) + q) % q;
    endfunction

    // X[k] = E[k] + w_k*O[k], X[k+4] = E[k] - w_k*O[k]; E/O are 4-point transforms of even/odd samples.
    function automatic logic [63:0] ref_ntt(logic [7:0][7:0] din, logic [3:0][7:0] om, logic [7:0] qq);
        int q;
        int x[8];
        int w[4];
        int y[2][4];
        logic [7:0][7:0] r;
        q = int'(qq);
        for (int i = 0; i < 8; i++) x[((i & 1) << 2) | (i & 2) | ((i >> 2) & 1)] = int'(din[i]);
        for (int k = 0; k < 4; k++) w[k] = int'(om[k]);
        for (int h = 0; h < 2; h++) begin
            int e0, e1, o0, o1;
            e0 = md(x[h] + w[0] * x[4+h], q);
            e1 = md(x[h] - w[0] * x[4+h], q);
            o0 = md(x[2+h] + w[0] * x[6+h], q);
            o1 = md(x[2+h] - w[0] * x[6+h], q);
            y[h][0] = md(e0 + w[0] * o0, q);
            y[h][2] = md(e0 - w[0] * o0, q);
            y[h][1] = md(e1 + w[2] * o1, q);
            y[h][3] = md(e1 - w[2] * o1, q);
        end
        for (int k = 0; k < 4; k++) begin
            r[k]   = 8'(md(y[0][k] + w[k] * y[1][k], q));
            r[k+4] = 8'(md(y[0][k] - w[k] * y[1][k], q));
        end
        return r;
    endfunction

    function automatic logic [63:0] pack8(int a[8]);
        logic [7:0][7:0] r;
        for (int i = 0; i < 8; i++) r[i] = 8'(a[i]);
        return r;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic set_std(int din[8]);
        valid_in = 1'b1;
        mod      = 8'd29;
        for (int k = 0; k < 4; k++) omegas[k] = 8'(std_om[k]);
        data_in = pack8(din);
    endtask

    // Push expectation for the current inputs, clock once, compare what emerges three edges later.
    task automatic tick();
        exp_t e;
        e.v = valid_in;
        e.d = valid_in ? ref_ntt(data_in, omegas, mod) : 64'd0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() > 3) begin
            e = exp_q.pop_front();
            if (e.v) last_d = e.d;
            chk("valid_out", 64'(valid_out), 64'(e.v));
        end else begin
            chk("fill_valid", 64'(valid_out), 64'd0);
        end
        chk("data_out", data_out, last_d);
    endtask

    task automatic bubble();
        valid_in = 1'b0;
        data_in  = 64'($urandom()) << 32 | 64'($urandom());
        tick();
    endtask

    initial begin
        int zero[8];
        int all28[8];
        int imp[8];
        logic over;
        tests  = 0;
        fails  = 0;
        last_d = '0;
        foreach (zero[i]) begin
            zero[i]  = 0;
            all28[i] = 28;
            imp[i]   = (i == 4) ? 1 : 0;
        end

        rst_n    = 1'b0;
        valid_in = 1'b1;
        data_in  = {$urandom(), $urandom()};
        omegas   = $urandom();
        mod      = 8'($urandom());
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", 64'(valid_out), 64'd0);
        chk("reset_data", data_out, 64'd0);
        valid_in = 1'b0;
        rst_n    = 1'b1;
        repeat (4) bubble();

        set_std(ref_in);
        tick();
        repeat (2) bubble();
        bubble();
        chk("ref_const", data_out, pack8(ref_out));
        repeat (2) bubble();

        set_std(ref_in);
        tick();
        set_std(imp);
        tick();
        set_std(zero);
        tick();
        bubble();
        chk("stream_ref", data_out, pack8(ref_out));
        bubble();
        chk("stream_imp", data_out, pack8(imp_out));
        bubble();
        chk("stream_zero", data_out, 64'd0);
        chk("stream_valid", 64'(valid_out), 64'd1);
        repeat (2) bubble();

        set_std(all28);
        omegas = {8'd28, 8'd28, 8'd28, 8'd1};
        tick();
        repeat (3) bubble();
        over = 1'b0;
        for (int i = 0; i < 8; i++) if (data_out[i] >= 8'd29) over = 1'b1;
        chk("wrap_below_q", 64'(over), 64'd0);
        chk("wrap_no_x", 64'($isunknown(data_out)), 64'd0);

        for (int n = 0; n < 60; n++) begin
            int q;
            q        = int'($urandom_range(2, 255));
            valid_in = ($urandom_range(0, 3) != 0);
            mod      = 8'(q);
            for (int k = 0; k < 4; k++) omegas[k] = 8'($urandom_range(0, q - 1));
            for (int i = 0; i < 8; i++) data_in[i] = 8'($urandom_range(0, q - 1));
            tick();
        end
        repeat (4) bubble();

        set_std(ref_in);
        tick();
        set_std(imp);
        tick();
        valid_in = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 64'(valid_out), 64'd0);
        chk("async_data", data_out, 64'd0);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        last_d = '0;
        repeat (4) bubble();
        set_std(imp);
        tick();
        repeat (2) bubble();
        bubble();
        chk("post_reset_imp", data_out, pack8(imp_out));
        chk("post_reset_valid", 64'(valid_out), 64'd1);
        repeat (2) bubble();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
